fp_issue_sched: RTL and testbench

FP_ISSUE_SCHED -- requirements
Module: fp_issue_sched

---
 rtl/fp_issue_sched.sv | 92 +++++++++
 tb/tb_fp_issue_sched.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_issue_sched.sv
// fp_issue_sched: round-robin issue of one FP op at a time to the execute unit, with FMA timeout and writeback hold.
module fp_issue_sched #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  input  logic [3:0]  req_is_fma,
  input  logic [19:0] req_tag,
  output logic [3:0]  req_ready,
  output logic        exe_enable,
  output logic [1:0]  exe_sel,
  input  logic        exe_ready,
  input  logic [31:0] exe_result,
  input  logic [4:0]  exe_flags,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_flags,
  output logic [4:0]  wb_tag,
  output logic [1:0]  wb_id,
  output logic [4:0]  fflags,
  input  logic        fflags_clr,
  output logic        err_timeout
);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t      state_q, state_d;
  logic [1:0]  rr_q, rr_d, id_q, id_d, g;
  logic        fma_q, fma_d;
  logic [4:0]  tag_q, tag_d, flags_q, flags_d, fflags_q, fflags_d;
  logic [31:0] res_q, res_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        grant, cap, tmo, hs;
  always_comb begin
    g = rr_q;
    for (int i = 4; i >= 1; i--)
      if (req_valid[rr_q + 2'(i)]) g = rr_q + 2'(i);
    grant = state_q == IDLE && |req_valid && !rst;
    cap   = state_q == EXEC && (!fma_q || exe_ready);
    tmo   = state_q == EXEC && fma_q && !exe_ready && cnt_q == 8'(TIMEOUT - 1);
    hs    = state_q == WB && wb_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= 2'd3;
      id_q     <= '0;
      fma_q    <= 1'b0;
      tag_q    <= '0;
      res_q    <= '0;
      flags_q  <= '0;
      fflags_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      id_q     <= id_d;
      fma_q    <= fma_d;
      tag_q    <= tag_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
      fflags_q <= fflags_d;
      cnt_q    <= cnt_d;
    end
  end
  always_comb begin
    state_d = grant ? EXEC : (cap || tmo) ? WB : hs ? IDLE : state_q;
  end
  always_comb begin
    rr_d     = grant ? g : rr_q;
    id_d     = grant ? g : id_q;
    fma_d    = grant ? req_is_fma[g] : fma_q;
    tag_d    = grant ? req_tag[5*g +: 5] : tag_q;
    cnt_d    = grant ? 8'd0 : state_q == EXEC ? cnt_q + 8'd1 : cnt_q;
    res_d    = cap ? exe_result : tmo ? 32'h0 : res_q;
    flags_d  = cap ? exe_flags : tmo ? 5'b10000 : flags_q;
    // a clear coincident with a handshake keeps only the new op's flags
    fflags_d = fflags_clr ? (hs ? flags_q : 5'b0) : hs ? fflags_q | flags_q : fflags_q;
  end
  always_comb begin
    req_ready   = grant ? 4'(1) << g : 4'b0;
    exe_enable  = state_q == EXEC;
    exe_sel     = state_q == EXEC ? id_q : 2'b0;
    wb_valid    = state_q == WB;
    wb_result   = res_q;
    wb_flags    = flags_q;
    wb_tag      = tag_q;
    wb_id       = id_q;
    fflags      = fflags_q;
    err_timeout = tmo;
  end
endmodule

// File: tb/tb_fp_issue_sched.sv
// tb_fp_issue_sched: scenario tasks against a transaction-level model of grant order, latency and sticky flags.
module tb_fp_issue_sched;
  localparam int TO = 8;
  logic        clk = 0, rst = 0;
  logic [3:0]  req_valid = 0, req_is_fma = 0, req_ready;
  logic [19:0] req_tag = 0;
  logic        exe_enable, exe_ready = 0, wb_valid, wb_ready = 0, fflags_clr = 0, err_timeout;
  logic [1:0]  exe_sel, wb_id;
  logic [31:0] exe_result = 0, wb_result;
  logic [4:0]  exe_flags = 0, wb_flags, wb_tag, fflags;
  int checks = 0, errors = 0;
  int m_rr = 3;
  logic [4:0] m_fflags = 0;

  fp_issue_sched #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_is_fma(req_is_fma), .req_tag(req_tag),
    .req_ready(req_ready), .exe_enable(exe_enable), .exe_sel(exe_sel), .exe_ready(exe_ready),
    .exe_result(exe_result), .exe_flags(exe_flags), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_result(wb_result), .wb_flags(wb_flags), .wb_tag(wb_tag), .wb_id(wb_id), .fflags(fflags),
    .fflags_clr(fflags_clr), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(int rr, logic [3:0] v);
    for (int k = 1; k <= 4; k++) if (v[(rr + k) % 4]) return (rr + k) % 4;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1;
    cyc();
    rst = 0;
    m_rr = 3;
    m_fflags = 0;
  endtask

  task automatic do_op(input int r, input logic [4:0] fl, input logic clr);
    req_valid = 4'(1) << r;
    req_is_fma = 0;
    cyc();
    req_valid = 0;
    exe_result = $urandom;
    exe_flags = fl;
    cyc();
    wb_ready = 1;
    fflags_clr = clr;
    cyc();
    wb_ready = 0;
    fflags_clr = 0;
    m_rr = r;
    m_fflags = clr ? fl : m_fflags | fl;
  endtask

  task automatic test_reset();
    rst = 1;
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_priority req_ready got %b exp 0000", req_ready); end
    cyc();
    rst = 0;
    req_valid = 0;
    #1;
    checks++;
    if ({req_ready, exe_enable, exe_sel, wb_valid, wb_result, wb_flags, wb_tag, wb_id, fflags, err_timeout} !== '0)
      begin errors++; $display("FAIL reset_outputs got %h exp 0", {req_ready, exe_enable, exe_sel, wb_valid, wb_result, wb_flags, wb_tag, wb_id, fflags, err_timeout}); end
    m_rr = 3;
    m_fflags = 0;
  endtask

  task automatic test_rr_order();
    int e;
    logic [4:0] fl;
    req_valid = 4'b1111;
    req_is_fma = 0;
    req_tag = {5'd13, 5'd12, 5'd11, 5'd10};
    wb_ready = 1;
    for (int n = 0; n < 5; n++) begin
      e = (m_rr + 1) % 4;
      #1;
      checks++;
      if (req_ready !== 4'(1) << e) begin errors++; $display("FAIL rr_grant op%0d got %b exp %b", n, req_ready, 4'(1) << e); end
      cyc();
      fl = 5'($urandom);
      exe_flags = fl;
      exe_result = $urandom;
      #1;
      checks++;
      if ({exe_enable, exe_sel, wb_valid} !== {1'b1, 2'(e), 1'b0}) begin errors++; $display("FAIL rr_exec op%0d got %b exp %b", n, {exe_enable, exe_sel, wb_valid}, {1'b1, 2'(e), 1'b0}); end
      cyc();
      checks++;
      if ({wb_valid, wb_id, wb_tag} !== {1'b1, 2'(e), 5'(10 + e)}) begin errors++; $display("FAIL rr_wb op%0d got %h exp %h", n, {wb_valid, wb_id, wb_tag}, {1'b1, 2'(e), 5'(10 + e)}); end
      cyc();
      m_rr = e;
      m_fflags |= fl;
    end
    req_valid = 0;
    wb_ready = 0;
    #1;
    checks++;
    if (fflags !== m_fflags) begin errors++; $display("FAIL rr_fflags got %b exp %b", fflags, m_fflags); end
  endtask

  task automatic test_random();
    logic [3:0] v, f;
    logic [19:0] tags;
    logic [31:0] res;
    logic [4:0] fl, tg;
    int g, w, s;
    logic isf;
    for (int n = 0; n < 40; n++) begin
      v = 4'($urandom_range(1, 15));
      f = 4'($urandom);
      tags = 20'($urandom);
      req_valid = v;
      req_is_fma = f;
      req_tag = tags;
      exe_ready = 0;
      #1;
      g = rr_pick(m_rr, v);
      isf = f[g];
      tg = tags[5*g +: 5];
      checks++;
      if (req_ready !== 4'(1) << g) begin errors++; $display("FAIL rand_grant op%0d got %b exp %b", n, req_ready, 4'(1) << g); end
      cyc();
      req_valid = 4'($urandom);
      req_is_fma = 4'($urandom);
      req_tag = 20'($urandom);
      w = isf ? $urandom_range(0, TO - 2) : 0;
      for (int i = 0; i <= w; i++) begin
        res = $urandom;
        fl = 5'($urandom);
        exe_result = res;
        exe_flags = fl;
        exe_ready = (i == w) ? (isf ? 1'b1 : 1'($urandom)) : 1'b0;
        #1;
        checks++;
        if ({exe_enable, exe_sel, err_timeout, wb_valid, req_ready} !== {1'b1, 2'(g), 2'b0, 4'b0})
          begin errors++; $display("FAIL rand_exec op%0d cyc%0d got %b exp %b", n, i, {exe_enable, exe_sel, err_timeout, wb_valid, req_ready}, {1'b1, 2'(g), 2'b0, 4'b0}); end
        cyc();
      end
      exe_result = $urandom;
      exe_ready = 1'($urandom);
      s = $urandom_range(0, 3);
      for (int j = 0; j <= s; j++) begin
        #1;
        checks++;
        if ({wb_valid, wb_result, wb_flags, wb_tag, wb_id, exe_enable, req_ready} !== {1'b1, res, fl, tg, 2'(g), 1'b0, 4'b0})
          begin errors++; $display("FAIL rand_wb op%0d got %h exp %h", n, {wb_valid, wb_result, wb_flags, wb_tag, wb_id, exe_enable, req_ready}, {1'b1, res, fl, tg, 2'(g), 1'b0, 4'b0}); end
        if (j == s) wb_ready = 1;
        cyc();
      end
      wb_ready = 0;
      req_valid = 0;
      m_rr = g;
      m_fflags |= fl;
      #1;
      checks++;
      if ({wb_valid, fflags} !== {1'b0, m_fflags}) begin errors++; $display("FAIL rand_fflags op%0d got %b exp %b", n, {wb_valid, fflags}, {1'b0, m_fflags}); end
    end
    exe_ready = 0;
  endtask

  task automatic test_fma_tag7();
    do_reset();
    req_valid = 4'b0100;
    req_is_fma = 4'b0100;
    req_tag = 20'(7) << 10;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL fma7_grant got %b exp 0100", req_ready); end
    cyc();
    req_valid = 0;
    for (int i = 0; i < 4; i++) cyc();
    exe_ready = 1;
    exe_result = 32'h3F800000;
    exe_flags = 5'b00001;
    #1;
    checks++;
    if ({exe_enable, wb_valid} !== 2'b10) begin errors++; $display("FAIL fma7_exec5 got %b exp 10", {exe_enable, wb_valid}); end
    cyc();
    exe_ready = 0;
    checks++;
    if ({wb_valid, wb_result, wb_flags, wb_tag, wb_id} !== {1'b1, 32'h3F800000, 5'b00001, 5'd7, 2'd2})
      begin errors++; $display("FAIL fma7_wb got %h exp %h", {wb_valid, wb_result, wb_flags, wb_tag, wb_id}, {1'b1, 32'h3F800000, 5'b00001, 5'd7, 2'd2}); end
    wb_ready = 1;
    cyc();
    wb_ready = 0;
    m_rr = 2;
    m_fflags = 5'b00001;
    checks++;
    if (fflags !== 5'b00001) begin errors++; $display("FAIL fma7_fflags got %b exp 00001", fflags); end
  endtask

  task automatic test_timeout(input logic ready_last);
    req_valid = 4'b0010;
    req_is_fma = 4'b0010;
    cyc();
    req_valid = 0;
    exe_result = 32'hDEAD_BEEF;
    exe_flags = 5'b00011;
    for (int k = 1; k <= TO; k++) begin
      exe_ready = (k == TO) && ready_last;
      #1;
      checks++;
      if ({exe_enable, err_timeout} !== {1'b1, k == TO && !ready_last})
        begin errors++; $display("FAIL timeout%0d cyc%0d got %b exp %b", ready_last, k, {exe_enable, err_timeout}, {1'b1, k == TO && !ready_last}); end
      cyc();
    end
    exe_ready = 0;
    checks++;
    if ({wb_valid, wb_result, wb_flags, wb_id, err_timeout} !== {1'b1, ready_last ? 32'hDEAD_BEEF : 32'h0, ready_last ? 5'b00011 : 5'b10000, 2'd1, 1'b0})
      begin errors++; $display("FAIL timeout%0d_wb got %h exp %h", ready_last, {wb_valid, wb_result, wb_flags, wb_id, err_timeout}, {1'b1, ready_last ? 32'hDEAD_BEEF : 32'h0, ready_last ? 5'b00011 : 5'b10000, 2'd1, 1'b0}); end
    wb_ready = 1;
    cyc();
    wb_ready = 0;
    m_rr = 1;
    m_fflags |= ready_last ? 5'b00011 : 5'b10000;
    checks++;
    if (fflags !== m_fflags) begin errors++; $display("FAIL timeout%0d_fflags got %b exp %b", ready_last, fflags, m_fflags); end
  endtask

  task automatic test_wb_stall();
    logic [31:0] res;
    res = $urandom;
    req_valid = 4'b0001;
    req_is_fma = 0;
    req_tag = 20'd21;
    cyc();
    exe_result = res;
    exe_flags = 5'b01000;
    cyc();
    req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      exe_result = $urandom;
      #1;
      checks++;
      if ({wb_valid, wb_result, wb_flags, wb_tag, wb_id, req_ready} !== {1'b1, res, 5'b01000, 5'd21, 2'd0, 4'b0})
        begin errors++; $display("FAIL stall cyc%0d got %h exp %h", i, {wb_valid, wb_result, wb_flags, wb_tag, wb_id, req_ready}, {1'b1, res, 5'b01000, 5'd21, 2'd0, 4'b0}); end
      cyc();
    end
    wb_ready = 1;
    #1;
    checks++;
    if (req_ready !== 4'b0) begin errors++; $display("FAIL stall_hs_grant got %b exp 0000", req_ready); end
    cyc();
    wb_ready = 0;
    m_rr = 0;
    m_fflags |= 5'b01000;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL stall_next_grant got %b exp 0010", req_ready); end
    req_valid = 0;
    cyc();
  endtask

  task automatic test_fflags_clr();
    fflags_clr = 1;
    cyc();
    fflags_clr = 0;
    m_fflags = 0;
    checks++;
    if (fflags !== 5'b0) begin errors++; $display("FAIL clr_alone got %b exp 00000", fflags); end
    do_op(3, 5'b00100, 1'b0);
    checks++;
    if (fflags !== m_fflags) begin errors++; $display("FAIL clr_set got %b exp %b", fflags, m_fflags); end
    do_op(0, 5'b00010, 1'b1);
    checks++;
    if (fflags !== 5'b00010) begin errors++; $display("FAIL clr_with_hs got %b exp 00010", fflags); end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0100;
    req_is_fma = 4'b0100;
    cyc();
    req_valid = 0;
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    m_rr = 3;
    m_fflags = 0;
    #1;
    checks++;
    if ({req_ready, exe_enable, exe_sel, wb_valid, wb_result, wb_flags, wb_tag, wb_id, fflags, err_timeout} !== '0)
      begin errors++; $display("FAIL rst_mid_outputs got %h exp 0", {req_ready, exe_enable, exe_sel, wb_valid, wb_result, wb_flags, wb_tag, wb_id, fflags, err_timeout}); end
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_mid_grant got %b exp 0001", req_ready); end
    req_valid = 0;
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    #1;
    test_reset();
    test_rr_order();
    test_random();
    test_fma_tag7();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_wb_stall();
    test_fflags_clr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
